// File: rtl/qpsk_deframer.sv
// qpsk_deframer: hunts a 16-bit sync word in a QPSK dibit stream, then packs payload dibits into bytes.
// Build option: define QPSK_DEFRAMER_SYNC_TOL_EN to accept a sync word with at most one bit error.
module qpsk_deframer #(
    parameter logic [15:0] SYNC_WORD     = 16'h1ACF,
    parameter int unsigned PAYLOAD_BYTES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  sym_i,
    input  logic        sym_valid_i,
    output logic [7:0]  byte_o,
    output logic        byte_valid_o,
    output logic        frame_start_o,
    output logic        frame_done_o,
    output logic        locked_o,
    output logic [15:0] frame_cnt_o
);
    localparam logic [7:0] LAST_BYTE = 8'(PAYLOAD_BYTES - 1);

    typedef enum logic {ST_HUNT, ST_PAYLOAD} state_t;

    state_t      r_state;
    logic [15:0] r_win;
    logic [3:0]  r_fill;
    logic [1:0]  r_dibit_cnt;
    logic [7:0]  r_byte_cnt;
    logic [5:0]  r_asm;
    logic [7:0]  r_byte;
    logic        r_byte_valid;
    logic        r_frame_start;
    logic        r_frame_done;
    logic        r_locked;
    logic [15:0] r_frame_cnt;

    logic [15:0] w_next_win;
    logic [15:0] w_diff;
    logic        w_pattern_ok;
    logic        w_sync_hit;
    logic        w_last_byte;

    assign w_next_win = {r_win[13:0], sym_i};
    assign w_diff     = w_next_win ^ SYNC_WORD;
`ifdef QPSK_DEFRAMER_SYNC_TOL_EN
    // A word with at most one set bit becomes zero when ANDed with itself minus one.
    assign w_pattern_ok = ((w_diff & (w_diff - 16'd1)) == 16'd0);
`else
    assign w_pattern_ok = (w_diff == 16'd0);
`endif
    // Fill of 7 before this edge means the incoming dibit is the 8th since entering HUNT.
    assign w_sync_hit  = w_pattern_ok && (r_fill >= 4'd7);
    assign w_last_byte = (r_byte_cnt == LAST_BYTE);

    // NOTE: all state below uses non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_HUNT;
            r_win         <= '0;
            r_fill        <= '0;
            r_dibit_cnt   <= '0;
            r_byte_cnt    <= '0;
            r_asm         <= '0;
            r_byte        <= '0;
            r_byte_valid  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
            r_locked      <= 1'b0;
            r_frame_cnt   <= '0;
        end else begin
            r_byte_valid  <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_done  <= 1'b0;
            // Lags the state by one cycle so lock stays up through the frame_done cycle.
            r_locked      <= (r_state == ST_PAYLOAD);
            if (sym_valid_i) begin
                case (r_state)
                    ST_HUNT: begin
                        r_win <= w_next_win;
                        if (r_fill != 4'd8) begin
                            r_fill <= r_fill + 4'd1;
                        end
                        if (w_sync_hit) begin
                            r_state       <= ST_PAYLOAD;
                            r_dibit_cnt   <= '0;
                            r_byte_cnt    <= '0;
                            r_frame_start <= 1'b1;
                            r_locked      <= 1'b1;
                        end
                    end
                    ST_PAYLOAD: begin
                        r_asm       <= {r_asm[3:0], sym_i};
                        r_dibit_cnt <= r_dibit_cnt + 2'd1;
                        if (r_dibit_cnt == 2'd3) begin
                            r_byte       <= {r_asm, sym_i};
                            r_byte_valid <= 1'b1;
                            r_byte_cnt   <= r_byte_cnt + 8'd1;
                            if (w_last_byte) begin
                                r_frame_done <= 1'b1;
                                r_frame_cnt  <= r_frame_cnt + 16'd1;
                                r_state      <= ST_HUNT;
                                r_win        <= '0;
                                r_fill       <= '0;
                            end
                        end
                    end
                    default: r_state <= ST_HUNT;
                endcase
            end
        end
    end

    assign byte_o        = r_byte;
    assign byte_valid_o  = r_byte_valid;
    assign frame_start_o = r_frame_start;
    assign frame_done_o  = r_frame_done;
    assign locked_o      = r_locked;
    assign frame_cnt_o   = r_frame_cnt;

endmodule
